// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
//   Shares one spi_if master between NREQ byte-transfer requesters using a
//   round-robin pointer. For each grant the arbiter (re)programs the baud
//   divisor through spi_if's cmd path when it differs from the last value
//   written, writes the TX byte, waits for irq, then reads the RX byte back.
//
// Ports
//   clk, rst        system clock; synchronous active-low reset
//   req[NREQ]       level request per requester, held until its done
//   wdata/baud      per-requester TX byte / baud divisor, 8 bits each,
//                   requester i at [8i+7:8i]; captured at grant
//   gnt[NREQ]       one-hot grant, high from grant through the done cycle
//   done[NREQ]      one-cycle one-hot completion pulse, rdata valid then
//   rdata           last received byte (8'h00 after an aborted transfer)
//   err             one-cycle pulse with done when a transfer timed out
//   spi_din/cmd/wr/rd, spi_dout/ack/irq
//                   spi_if bus-side port
//   state_dbg       current FSM state encoding
//
// spi_if handshake: a request is spi_wr or spi_rd high together with stable
// spi_cmd/spi_din. All of them are decoded purely from the FSM state, so they
// cannot change until the state moves, and the state only moves on spi_ack
// (or on timeout). The cycle after spi_ack the strobes reflect the next state.
module spi_xfer_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] wdata,
    input  logic [8*NREQ-1:0] baud,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              err,
    output logic [7:0]        spi_din,
    output logic              spi_cmd,
    output logic              spi_wr,
    output logic              spi_rd,
    input  logic [7:0]        spi_dout,
    input  logic              spi_ack,
    input  logic              spi_irq,
    output logic [2:0]        state_dbg
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CFG  = 3'd1,
        S_XFER = 3'd2,
        S_WAIT = 3'd3,
        S_READ = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx_q, rr_q, rr_adv;
    logic [7:0]    wdata_q, baud_q, cache_q, rdata_q;
    logic [9:0]    timer_q;
    logic          abort_q;
    logic          abort_now;
    logic          busy;
    logic          timeout_hit;

    // Round-robin pick: first set request at or after rr_q, wrapping.
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic [7:0]    pick_wdata, pick_baud;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        pick_wdata = 8'h00;
        pick_baud  = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(rr_q) + k) % NREQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_wdata = wdata[8*i +: 8];
                pick_baud  = baud[8*i +: 8];
            end
        end
    end

    assign busy        = (state == S_CFG) || (state == S_XFER) ||
                         (state == S_WAIT) || (state == S_READ);
    assign timeout_hit = (timer_q == 10'(TIMEOUT));
    assign rr_adv      = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    // Next-state logic. In every waiting state the awaited event is tested
    // before the timeout, so an ack landing on the last cycle still wins.
    always_comb begin
        state_nxt = state;
        abort_now = 1'b0;
        unique case (state)
            S_IDLE: if (pick_found) state_nxt = (pick_baud != cache_q) ? S_CFG : S_XFER;
            S_CFG:  if (spi_ack) state_nxt = S_XFER; else if (timeout_hit) abort_now = 1'b1;
            S_XFER: if (spi_ack) state_nxt = S_WAIT; else if (timeout_hit) abort_now = 1'b1;
            S_WAIT: if (spi_irq) state_nxt = S_READ; else if (timeout_hit) abort_now = 1'b1;
            S_READ: if (spi_ack) state_nxt = S_DONE; else if (timeout_hit) abort_now = 1'b1;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Aborts finish through DONE so done/err pulse while gnt is still up.
        if (abort_now) state_nxt = S_DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= '0;
            rr_q    <= '0;
            wdata_q <= 8'h00;
            baud_q  <= 8'h00;
            cache_q <= 8'h00;
            rdata_q <= 8'h00;
            timer_q <= 10'd0;
            abort_q <= 1'b0;
        end else begin
            if (state_nxt != state) timer_q <= 10'd0;
            else if (busy)          timer_q <= timer_q + 10'd1;

            if (state == S_IDLE && pick_found) begin
                idx_q   <= pick_idx;
                wdata_q <= pick_wdata;
                baud_q  <= pick_baud;
                abort_q <= 1'b0;
            end
            if (state == S_CFG && spi_ack)  cache_q <= baud_q;
            if (state == S_READ && spi_ack) rdata_q <= spi_dout;
            // Clearing the cache forces a fresh settings write next time,
            // since spi_if's state is unknown after an abort.
            if (abort_now) begin
                abort_q <= 1'b1;
                rdata_q <= 8'h00;
                cache_q <= 8'h00;
            end
            if (state == S_DONE) rr_q <= rr_adv;
        end
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        if (state != S_IDLE) gnt[idx_q]  = 1'b1;
        if (state == S_DONE) done[idx_q] = 1'b1;
    end

    assign err       = (state == S_DONE) && abort_q;
    assign rdata     = rdata_q;
    assign spi_cmd   = (state == S_CFG);
    assign spi_wr    = (state == S_CFG) || (state == S_XFER);
    assign spi_rd    = (state == S_READ);
    assign spi_din   = (state == S_CFG)  ? baud_q  :
                       (state == S_XFER) ? wdata_q : 8'h00;
    assign state_dbg = state;

endmodule
